// File: rtl/pixel_encoder_pkg.sv
// Shared widths, types and the lowest-set-bit priority encoder for the 128-pixel readout.
package pixel_encoder_pkg;

  localparam int NPIX       = 128;
  localparam int IDX_W      = 7;
  localparam int ADDR_W     = 8;
  localparam int FIFO_DEPTH = 16;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } lsi_t;

  // Scan downward so the last assignment made is the lowest set index.
  function automatic lsi_t lowest_set_index(input logic [NPIX-1:0] vec);
    lsi_t res;
    res.found = |vec;
    res.idx   = '0;
    for (int i = NPIX - 1; i >= 0; i--) begin
      if (vec[i]) begin
        res.idx = IDX_W'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/pixel_encoder_128_fifo.sv
// Synchronous FIFO: write visible at head one cycle after push; full/empty are registered.
// Push when full and pop when empty are ignored internally.
module pe_sync_fifo
  import pixel_encoder_pkg::*;
#(
  parameter int WIDTH = IDX_W,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_full;
  logic             r_empty;

  logic             w_push;
  logic             w_pop;
  logic [CNT_W-1:0] w_count_nxt;

  assign w_push = i_push & ~r_full;
  assign w_pop  = i_pop & ~r_empty;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage carries no reset; occupancy is tracked entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/pixel_encoder_128.sv
// 128-pixel column readout: one lowest-index hit encoded per cycle into a FIFO, clear pulse next cycle.
// Hits wait while the FIFO is full; each clkout rising edge (with readout) pops one word onto addr next cycle.
module pixel_encoder_128
  import pixel_encoder_pkg::*;
(
  input  logic              clk,
  input  logic              reset_pe,
  input  logic [NPIX-1:0]   state,
  input  logic              read,
  input  logic              en,
  input  logic              readout,
  input  logic              clkout,
  output logic [ADDR_W-1:0] addr,
  output logic [NPIX-1:0]   reset,
  output logic              full,
  output logic              empty
);

  logic [NPIX-1:0]   r_mask;
  logic [NPIX-1:0]   r_reset;
  logic [ADDR_W-1:0] r_addr;
  logic              r_clkout_q;

  logic [NPIX-1:0]   w_pending;
  lsi_t              w_lsi;
  logic              w_push;
  logic              w_pop_req;
  logic              w_pop_try;
  logic              w_pop;
  logic [NPIX-1:0]   w_hit_onehot;
  logic [IDX_W-1:0]  w_head;
  logic              w_full;
  logic              w_empty;

  // A pixel already queued stays masked until its hit flag drops.
  assign w_pending = state & ~r_mask;
  assign w_lsi     = lowest_set_index(w_pending);

  // full is the registered value from the start of the cycle, so a pop from a
  // full FIFO never lets a same-cycle push through.
  assign w_push       = en & read & ~w_full & w_lsi.found;
  assign w_hit_onehot = w_push ? (NPIX'(1) << w_lsi.idx) : '0;

  assign w_pop_req = clkout & ~r_clkout_q;
  assign w_pop_try = en & readout & w_pop_req;
  assign w_pop     = w_pop_try & ~w_empty;

  pe_sync_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .i_reset (reset_pe),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_lsi.idx),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (reset_pe) begin
      r_clkout_q <= 1'b0;
    end else begin
      r_clkout_q <= clkout;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_pe) begin
      r_mask <= '0;
    end else if (en) begin
      r_mask <= (r_mask & state) | w_hit_onehot;
    end
  end

  // Global clear during reset; otherwise a single-cycle one-hot per encoded hit.
  always_ff @(posedge clk) begin
    if (reset_pe) begin
      r_reset <= '1;
    end else begin
      r_reset <= w_hit_onehot;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_pe) begin
      r_addr <= '0;
    end else if (w_pop_try) begin
      r_addr <= w_empty ? '0 : {1'b1, w_head};
    end
  end

  assign addr  = r_addr;
  assign reset = r_reset;
  assign full  = w_full;
  assign empty = w_empty;

endmodule

// File: tb/tb_pixel_encoder_128.sv
// Directed self-checking bench for pixel_encoder_128.
module tb_pixel_encoder_128;

  logic         clk;
  logic         reset_pe;
  logic [127:0] state;
  logic         read;
  logic         en;
  logic         readout;
  logic         clkout;
  logic [7:0]   addr;
  logic [127:0] pix_reset;
  logic         full;
  logic         empty;

  int checks = 0;
  int errors = 0;

  pixel_encoder_128 dut (
    .clk      (clk),
    .reset_pe (reset_pe),
    .state    (state),
    .read     (read),
    .en       (en),
    .readout  (readout),
    .clkout   (clkout),
    .addr     (addr),
    .reset    (pix_reset),
    .full     (full),
    .empty    (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] onehot(input int i);
    logic [127:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic test_reset();
    logic [127:0] exp_all;
    exp_all = '1;
    reset_pe = 1'b1; state = '0; read = 1'b0; en = 1'b0; readout = 1'b0; clkout = 1'b0;
    step(); step();
    checks++; if (pix_reset !== exp_all) begin errors++; $display("FAIL reset_all got %h want %h", pix_reset, exp_all); end
    checks++; if (addr !== 8'h00) begin errors++; $display("FAIL reset_addr got %h want 00", addr); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
    reset_pe = 1'b0;
    step();
    checks++; if (pix_reset !== '0) begin errors++; $display("FAIL reset_release got %h want 0", pix_reset); end
  endtask

  task automatic test_capture();
    state = 128'h7FFF_FFFF; read = 1'b1; en = 1'b1; readout = 1'b0;
    for (int c = 0; c < 16; c++) begin
      step();
      checks++; if (pix_reset !== onehot(c)) begin errors++; $display("FAIL capture_pulse%0d got %h want %h", c, pix_reset, onehot(c)); end
    end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL capture_full got %b want 1", full); end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (pix_reset !== '0) begin errors++; $display("FAIL capture_stall%0d got %h want 0", c, pix_reset); end
    end
  endtask

  task automatic test_drain();
    logic [7:0] exp_a;
    readout = 1'b1;
    for (int n = 0; n < 31; n++) begin
      exp_a = {1'b1, 7'(n)};
      clkout = 1'b1;
      step();
      checks++; if (addr !== exp_a) begin errors++; $display("FAIL drain_addr%0d got %h want %h", n, addr, exp_a); end
      step();
      if (n < 15) begin
        checks++; if (pix_reset !== onehot(16 + n)) begin errors++; $display("FAIL drain_refill%0d got %h want %h", n, pix_reset, onehot(16 + n)); end
      end
      clkout = 1'b0;
      step(); step();
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b want 1", empty); end
    clkout = 1'b1;
    step();
    checks++; if (addr !== 8'h00) begin errors++; $display("FAIL drain_pop_empty got %h want 00", addr); end
    clkout = 1'b0;
    step();
  endtask

  task automatic test_gating();
    logic [7:0] exp_a;
    readout = 1'b0;
    state = '0;
    step();
    state = 128'h7;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (pix_reset !== onehot(i)) begin errors++; $display("FAIL gate_fill%0d got %h want %h", i, pix_reset, onehot(i)); end
    end
    for (int i = 0; i < 4; i++) begin
      clkout = ~clkout;
      step();
    end
    checks++; if (addr !== 8'h00) begin errors++; $display("FAIL gate_addr got %h want 00", addr); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL gate_empty got %b want 0", empty); end
    clkout = 1'b0; readout = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      exp_a = {1'b1, 7'(i)};
      clkout = 1'b1; step();
      checks++; if (addr !== exp_a) begin errors++; $display("FAIL gate_drain%0d got %h want %h", i, addr, exp_a); end
      clkout = 1'b0; step();
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL gate_count got empty %b want 1", empty); end
    readout = 1'b0;
  endtask

  task automatic test_rehit();
    state = 128'h8;
    step();
    checks++; if (pix_reset !== onehot(3)) begin errors++; $display("FAIL rehit_first got %h want %h", pix_reset, onehot(3)); end
    step();
    checks++; if (pix_reset !== '0) begin errors++; $display("FAIL rehit_held got %h want 0", pix_reset); end
    state = '0; step();
    state = 128'h8; step();
    checks++; if (pix_reset !== onehot(3)) begin errors++; $display("FAIL rehit_second got %h want %h", pix_reset, onehot(3)); end
    readout = 1'b1;
    for (int i = 0; i < 2; i++) begin
      clkout = 1'b1; step();
      checks++; if (addr !== 8'h83) begin errors++; $display("FAIL rehit_addr%0d got %h want 83", i, addr); end
      clkout = 1'b0; step();
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rehit_empty got %b want 1", empty); end
    readout = 1'b0;
  endtask

  task automatic test_midrun_reset();
    logic [127:0] exp_all;
    exp_all = '1;
    state = '0; step();
    state = 128'h1F;
    for (int i = 0; i < 5; i++) step();
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL midrun_queued got empty %b want 0", empty); end
    reset_pe = 1'b1; step();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL midrun_empty got %b want 1", empty); end
    checks++; if (pix_reset !== exp_all) begin errors++; $display("FAIL midrun_clear got %h want %h", pix_reset, exp_all); end
    reset_pe = 1'b0; step();
    checks++; if (pix_reset !== onehot(0)) begin errors++; $display("FAIL midrun_reenc0 got %h want %h", pix_reset, onehot(0)); end
    step();
    checks++; if (pix_reset !== onehot(1)) begin errors++; $display("FAIL midrun_reenc1 got %h want %h", pix_reset, onehot(1)); end
  endtask

  task automatic test_enable();
    en = 1'b0; readout = 1'b1; clkout = 1'b1;
    step();
    checks++; if (pix_reset !== '0) begin errors++; $display("FAIL en_frozen_pulse got %h want 0", pix_reset); end
    checks++; if (addr !== 8'h00) begin errors++; $display("FAIL en_frozen_addr got %h want 00", addr); end
    clkout = 1'b0; readout = 1'b0; en = 1'b1;
    step();
    checks++; if (pix_reset !== onehot(2)) begin errors++; $display("FAIL en_resume got %h want %h", pix_reset, onehot(2)); end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_drain();
    test_gating();
    test_rehit();
    test_midrun_reset();
    test_enable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_encoder_128.md
Name: pixel_encoder_128

Overview:
- Readout front-end for one 128-pixel column group of the CMOS pixel sensor.
- Each cycle it priority-encodes pending hit pixels (lowest index first) and pushes each hit's index into an internal FIFO.
- It pulses a per-pixel clear line for every encoded hit.
- The FIFO is drained onto an 8-bit address bus on rising edges of a readout strobe.

Parameters:
- NPIX, 128, number of pixel inputs (fixed; index width 7).
- FIFO_DEPTH, 16, FIFO entries (power of two).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_pe  input  1  synchronous, active-high reset.
- state  input  128  pixel hit flags; bit i=1 means pixel i is hit (level).
- read  input  1  encode enable; hits are captured only while high.
- en  input  1  block enable; when low, no push, no pop, and registers hold.
- readout  input  1  readout enable; pops are allowed only while high.
- clkout  input  1  readout strobe, synchronous to clk; a rising edge requests one pop.
- addr  output  8  readout word: bit 7 = valid, bits 6:0 = pixel index.
- reset  output  128  per-pixel clear pulses, registered.
- full  output  1  FIFO holds FIFO_DEPTH entries.
- empty  output  1  FIFO holds 0 entries.

Behaviour:
- Clocking and reset: one clock (clk); reset_pe is synchronous and active-high.
- During any cycle with reset_pe high:
  - FIFO count cleared; empty=1, full=0.
  - addr=8'h00.
  - served mask cleared.
  - clkout history register set to 0.
  - reset output loaded with all ones (global pixel clear). It returns to 0 on the first cycle after reset_pe falls.
- Served mask (128 bits):
  - Bit i is set when pixel i is pushed.
  - Bit i is cleared in any cycle where state[i]=0.
  - pending = state & ~mask, so a held hit is encoded exactly once until it drops.
- Encode/push, per cycle with en=1, read=1, full=0 and pending!=0:
  - k = lowest set index of pending.
  - Push k into the FIFO and set mask[k].
  - reset register becomes one-hot bit k for exactly one cycle, visible the cycle after the push. Otherwise reset=0.
- Push rate is at most one per cycle. No push when full; a hit waits until space frees.
- Strobe detect: clkout_q <= clkout every cycle. pop_req = clkout & ~clkout_q.
- Pop, when en=1, readout=1, pop_req=1:
  - If not empty: addr <= {1'b1, head index} next cycle, head advances, count decrements.
  - If empty: addr <= 8'h00.
  - A pop_req while readout=0 is discarded; addr keeps its value.
- Simultaneous push and pop in one cycle:
  - Both take effect and the count is unchanged.
  - Push eligibility uses full from the start of the cycle.
  - A pop from a full FIFO plus a push in the same cycle is not allowed; the push waits one cycle.
- FIFO pointers wrap modulo FIFO_DEPTH. full and empty are registered from the count.
- en=0: push, pop and mask updates are frozen. The reset output is 0 (except during reset_pe). clkout_q still tracks clkout.
- reset_pe asserted mid-operation discards all FIFO contents and mask state immediately (same edge).

Decomposition:
- Package pixel_encoder_pkg:
  - NPIX=128, IDX_W=7, ADDR_W=8, FIFO_DEPTH default.
  - Function lowest_set_index(128-bit) returning found flag plus 7-bit index.
- One sub-module: pe_sync_fifo (IDX_W wide, FIFO_DEPTH deep).
  - Ports: push, pop, din, dout, full, empty, synchronous reset.
- Encoder, mask, strobe detect and addr register stay in the top.

Test Plan:
- Reset: hold reset_pe 2 cycles with state=0 → reset=all ones, addr=0x00, empty=1, full=0. One cycle after release, reset=0.
- Ordered capture: state=0x7FFFFFFF, read=1, en=1, readout=0 → on cycles 1..16, reset pulses one-hot at bits 0..15 in order. full=1 after 16 pushes, then pushes stall with no reset pulses.
- Drain: from the previous state, set readout=1 and toggle clkout every 2 cycles → addr reads 0x80,0x81,…; the stalled pixels 16..30 are pushed as space frees. After 31 pops empty=1, and further strobes give addr=0x00.
- Readout gating: readout=0 with clkout toggling and a non-empty FIFO → addr unchanged, count unchanged.
- Re-hit: after pixel 3 is served, drop state[3] for one cycle, then raise it → pixel 3 is encoded and pushed again, with a new reset[3] pulse.
- Mid-run reset: assert reset_pe with 5 entries queued → empty=1 next cycle and reset=all ones. After release, held hits are re-encoded starting at index 0.
